// File: rtl/multi_spi_pkg.sv
// Shared definitions for the multi-lane SPI loaders and the transmit serialiser.
package multi_spi_pkg;

    localparam int DEFAULT_LANES = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } spi_state_e;

    function automatic int beat_count(input int regsize, input int lanes);
        return regsize / lanes;
    endfunction

    // Counters need at least one bit even when their range is a single value.
    function automatic int cnt_width(input int range_n);
        return (range_n > 1) ? $clog2(range_n) : 1;
    endfunction

endpackage

// File: rtl/multi_spi_beat_timer.sv
// Beat pacing for the serialiser: holds each beat DIV cycles and tracks which beat is on the bus.
module multi_spi_beat_timer
    import multi_spi_pkg::*;
#(
    parameter int NBEATS = 8,
    parameter int DIV    = 1
)(
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic run,
    output logic beat_adv,
    output logic last_beat
);

    localparam int DW = cnt_width(DIV);
    localparam int BW = cnt_width(NBEATS);
    localparam logic [DW-1:0] DIV_MAX  = DW'(DIV - 1);
    localparam logic [BW-1:0] BEAT_MAX = BW'(NBEATS - 1);

    logic [DW-1:0] div_cnt;
    logic [BW-1:0] beat_cnt;

    assign beat_adv  = run && (div_cnt == DIV_MAX);
    assign last_beat = (beat_cnt == BEAT_MAX);

    // The beat counter parks on its terminal value so a trailing parity beat reuses the divider.
    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            div_cnt  <= '0;
            beat_cnt <= '0;
        end else if (run) begin
            if (div_cnt == DIV_MAX) begin
                div_cnt <= '0;
                if (!last_beat) begin
                    beat_cnt <= beat_cnt + 1'b1;
                end
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/multi_spi_tx.sv
// Serialises a result word onto a LANES-wide bus, MSB beat first, with valid/done strobes.
// Optional trailing XOR-fold parity beat enabled by defining MULTI_SPI_TX_PARITY_EN.
module multi_spi_tx
    import multi_spi_pkg::*;
#(
    parameter int REGSIZE = 32,
    parameter int LANES   = DEFAULT_LANES,
    parameter int DIV     = 1
)(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic [REGSIZE-1:0] data_in,
    input  logic               abort,
    output logic               ready,
    output logic [LANES-1:0]   O,
    output logic               valid,
    output logic               done
);

    localparam int BEATS = beat_count(REGSIZE, LANES);

    generate
        if ((REGSIZE % LANES) != 0 || DIV < 1) begin : g_param_check
            $error("multi_spi_tx: REGSIZE must be a multiple of LANES and DIV must be >= 1");
        end
    endgenerate

    spi_state_e         state, state_next;
    logic [REGSIZE-1:0] shift_reg, shift_next;
    logic [LANES-1:0]   o_next;
    logic               valid_next, done_next;
    logic               timer_clear, timer_run, beat_adv, last_beat;

`ifdef MULTI_SPI_TX_PARITY_EN
    logic [LANES-1:0] parity_reg, parity_next;

    function automatic logic [LANES-1:0] lane_fold(input logic [REGSIZE-1:0] word);
        logic [LANES-1:0] acc;
        acc = '0;
        for (int i = 0; i < BEATS; i++) begin
            acc ^= word[i*LANES +: LANES];
        end
        return acc;
    endfunction
`endif

    assign ready       = (state == IDLE);
    assign timer_run   = (state != IDLE);
    assign timer_clear = (state == IDLE) || abort;

    multi_spi_beat_timer #(
        .NBEATS (BEATS),
        .DIV    (DIV)
    ) u_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (timer_clear),
        .run       (timer_run),
        .beat_adv  (beat_adv),
        .last_beat (last_beat)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            shift_reg <= '0;
            O         <= '0;
            valid     <= 1'b0;
            done      <= 1'b0;
`ifdef MULTI_SPI_TX_PARITY_EN
            parity_reg <= '0;
`endif
        end else begin
            state     <= state_next;
            shift_reg <= shift_next;
            O         <= o_next;
            valid     <= valid_next;
            done      <= done_next;
`ifdef MULTI_SPI_TX_PARITY_EN
            parity_reg <= parity_next;
`endif
        end
    end

    // shift_reg holds only the beats still to come, already aligned to the top.
    always_comb begin
        state_next = state;
        shift_next = shift_reg;
        o_next     = O;
        valid_next = valid;
        done_next  = 1'b0;
`ifdef MULTI_SPI_TX_PARITY_EN
        parity_next = parity_reg;
`endif
        case (state)
            IDLE: begin
                o_next     = '0;
                valid_next = 1'b0;
                if (load && !abort) begin
                    shift_next = data_in << LANES;
                    o_next     = data_in[REGSIZE-1 -: LANES];
                    valid_next = 1'b1;
                    state_next = SHIFT;
`ifdef MULTI_SPI_TX_PARITY_EN
                    parity_next = lane_fold(data_in);
`endif
                end
            end
            SHIFT: begin
                if (abort) begin
                    state_next = IDLE;
                    o_next     = '0;
                    valid_next = 1'b0;
                end else if (beat_adv) begin
                    if (last_beat) begin
`ifdef MULTI_SPI_TX_PARITY_EN
                        state_next = PARITY;
                        o_next     = parity_reg;
`else
                        state_next = IDLE;
                        o_next     = '0;
                        valid_next = 1'b0;
                        done_next  = 1'b1;
`endif
                    end else begin
                        shift_next = shift_reg << LANES;
                        o_next     = shift_reg[REGSIZE-1 -: LANES];
                    end
                end
            end
            PARITY: begin
                if (abort) begin
                    state_next = IDLE;
                    o_next     = '0;
                    valid_next = 1'b0;
                end else if (beat_adv) begin
                    state_next = IDLE;
                    o_next     = '0;
                    valid_next = 1'b0;
                    done_next  = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                o_next     = '0;
                valid_next = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_multi_spi_tx.sv
// Self-checking bench for multi_spi_tx: vector table plus scoreboarded beat streams (DIV=1 and DIV=3).
module tb_multi_spi_tx;

`ifdef MULTI_SPI_TX_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    typedef struct {
        logic        rst_n;
        logic        load;
        logic        abort;
        logic [31:0] data;
        logic        push;
        logic        exp_ready;
        logic        exp_valid;
        logic        exp_done;
        logic [3:0]  exp_o;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n, load, abort, load3, abort3;
    logic [31:0] data_in, data3;
    logic        ready, valid, done, ready3, valid3, done3;
    logic [3:0]  O, O3;

    logic [3:0]  exp_q[$];
    logic [3:0]  exp_q3[$];
    vec_t        vecs[$];
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    multi_spi_tx #(.REGSIZE(32), .LANES(4), .DIV(1)) u_dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (load),
        .data_in (data_in),
        .abort   (abort),
        .ready   (ready),
        .O       (O),
        .valid   (valid),
        .done    (done)
    );

    multi_spi_tx #(.REGSIZE(32), .LANES(4), .DIV(3)) u_dut3 (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (load3),
        .data_in (data3),
        .abort   (abort3),
        .ready   (ready3),
        .O       (O3),
        .valid   (valid3),
        .done    (done3)
    );

    function automatic logic [3:0] beat_of(input logic [31:0] d, input int i);
        return d[31-4*i -: 4];
    endfunction

    function automatic logic [3:0] fold_of(input logic [31:0] d);
        logic [3:0] acc;
        acc = 4'h0;
        for (int i = 0; i < 8; i++) acc ^= beat_of(d, i);
        return acc;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask

    // Expected beats for one frame; the DIV=3 stream expects every beat three times.
    task automatic push_frame(input logic [31:0] d, input int which);
        int reps;
        reps = (which == 3) ? 3 : 1;
        for (int i = 0; i < 8 + (PAR ? 1 : 0); i++) begin
            for (int r = 0; r < reps; r++) begin
                if (which == 3) exp_q3.push_back((i < 8) ? beat_of(d, i) : fold_of(d));
                else            exp_q.push_back((i < 8) ? beat_of(d, i) : fold_of(d));
            end
        end
    endtask

    task automatic add_row(input logic r, input logic l, input logic a, input logic [31:0] d,
                           input logic p, input logic er, input logic ev, input logic ed,
                           input logic [3:0] eo);
        vec_t v;
        v.rst_n = r; v.load = l; v.abort = a; v.data = d; v.push = p;
        v.exp_ready = er; v.exp_valid = ev; v.exp_done = ed; v.exp_o = eo;
        vecs.push_back(v);
    endtask

    // Mid-frame load pulse and changing data_in must not disturb the frame in flight.
    task automatic add_frame(input logic [31:0] d);
        add_row(1, 1, 0, d, 1, 0, 1, 0, beat_of(d, 0));
        for (int i = 1; i < 8; i++) add_row(1, (i == 2), 0, ~d, 0, 0, 1, 0, beat_of(d, i));
        if (PAR) add_row(1, 0, 0, 32'h0, 0, 0, 1, 0, fold_of(d));
        add_row(1, 0, 0, 32'h0, 0, 1, 0, 1, 4'h0);
        add_row(1, 0, 0, 32'h0, 0, 1, 0, 0, 4'h0);
    endtask

    task automatic applyStimulus(input vec_t v);
        rst_n   = v.rst_n;
        load    = v.load;
        abort   = v.abort;
        data_in = v.data;
        if (v.push) push_frame(v.data, 1);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL sb_unexpected_beat got %0h expected no beat", O);
            end else begin
                checkOutput("sb_beat", O, exp_q.pop_front());
            end
        end
        if (valid3 === 1'b1) begin
            if (exp_q3.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL sb3_unexpected_beat got %0h expected no beat", O3);
            end else begin
                checkOutput("sb3_beat", O3, exp_q3.pop_front());
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog timeout");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n, vcount;
        bit seen;

        rst_n = 1'b0; load = 1'b0; abort = 1'b0; data_in = '0;
        load3 = 1'b0; abort3 = 1'b0; data3 = '0;

        add_row(0, 1, 0, 32'hDEADBEEF, 0, 1, 0, 0, 4'h0);
        add_row(0, 1, 0, 32'hDEADBEEF, 0, 1, 0, 0, 4'h0);
        add_row(1, 0, 0, 32'h0,        0, 1, 0, 0, 4'h0);
        add_row(1, 1, 1, 32'hFFFFFFFF, 0, 1, 0, 0, 4'h0);
        add_row(1, 0, 1, 32'h0,        0, 1, 0, 0, 4'h0);
        add_frame(32'h12345678);
        add_frame(32'hF0E1D2C3);

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
            step();
            checkOutput($sformatf("v%0d_ready", i), ready, vecs[i].exp_ready);
            checkOutput($sformatf("v%0d_valid", i), valid, vecs[i].exp_valid);
            checkOutput($sformatf("v%0d_done", i),  done,  vecs[i].exp_done);
            checkOutput($sformatf("v%0d_O", i),     O,     vecs[i].exp_o);
        end
        rst_n = 1'b1; load = 1'b0; abort = 1'b0; data_in = '0;

        $display("[TB] DIV=3 hold test");
        load3 = 1'b1; data3 = 32'hA5000000;
        push_frame(data3, 3);
        step();
        load3 = 1'b0;
        checkOutput("div3_first_beat", O3, 32'hA);
        vcount = 0; seen = 0;
        for (int i = 0; i < 60; i++) begin
            if (done3) begin
                seen = 1;
                break;
            end
            if (valid3) vcount++;
            step();
        end
        checkOutput("div3_done_seen", seen, 1);
        checkOutput("div3_valid_cycles", vcount, PAR ? 27 : 24);
        checkOutput("div3_ready_at_done", ready3, 1);
        checkOutput("div3_O_at_done", O3, 0);

        $display("[TB] back-to-back test");
        load = 1'b1; data_in = 32'h9ABCDEF0;
        push_frame(data_in, 1);
        step();
        checkOutput("b2b_first_beat", O, 32'h9);
        data_in = 32'h3C3C3C3C;
        n = 0; seen = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            n++;
            if (done) begin
                seen = 1;
                break;
            end
        end
        checkOutput("b2b_done_seen", seen, 1);
        checkOutput("b2b_steps_to_done", n, PAR ? 9 : 8);
        checkOutput("b2b_ready_at_done", ready, 1);
        push_frame(32'h3C3C3C3C, 1);
        step();
        load = 1'b0;
        checkOutput("b2b_second_valid", valid, 1);
        checkOutput("b2b_second_beat0", O, 32'h3);
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (done) begin
                seen = 1;
                break;
            end
        end
        checkOutput("b2b_second_done_seen", seen, 1);
        step();

        $display("[TB] abort test");
        load = 1'b1; data_in = 32'h12345678;
        for (int i = 0; i < 4; i++) exp_q.push_back(beat_of(32'h12345678, i));
        step();
        load = 1'b0;
        step();
        step();
        step();
        checkOutput("abort_beat3", O, 32'h4);
        abort = 1'b1;
        step();
        abort = 1'b0;
        checkOutput("abort_valid", valid, 0);
        checkOutput("abort_O", O, 0);
        checkOutput("abort_done", done, 0);
        checkOutput("abort_ready", ready, 1);
        step();
        checkOutput("abort_no_done_later", done, 0);

        $display("[TB] reset mid-frame test");
        load = 1'b1; data_in = 32'h12345678;
        for (int i = 0; i < 3; i++) exp_q.push_back(beat_of(32'h12345678, i));
        step();
        load = 1'b0;
        step();
        step();
        checkOutput("rst_mid_beat2", O, 32'h3);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        checkOutput("rst_mid_valid", valid, 0);
        checkOutput("rst_mid_O", O, 0);
        checkOutput("rst_mid_ready", ready, 1);
        checkOutput("rst_mid_done", done, 0);
        step();
        checkOutput("rst_mid_no_done_later", done, 0);
        step();

        checkOutput("sb_queue_drained", exp_q.size(), 0);
        checkOutput("sb3_queue_drained", exp_q3.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
